// File: rtl/fpu_cmp_arbiter_16bit.sv
// Round-robin arbiter sharing one half-precision comparator among NUM_REQ requesters.
// Latency: 1 cycle from grant (req_ready) to registered resp_valid/resp_id/resp_out.
// Backpressure: a held result (resp_valid && !resp_ready) blocks all grants; drain+grant replaces in one edge.

package fpu_cmp_pkg;
  localparam int HALF_FLOAT_W = 16;

  typedef enum logic [2:0] {
    CMP_LE = 3'b000,
    CMP_LT = 3'b001,
    CMP_EQ = 3'b010
  } fpu_cmp_rm_t;
endpackage

// Half-precision compare: any NaN operand gives 0, +0 and -0 compare equal.
// Combinational; unused op encodings give 0.
module float_compare_16bit
  import fpu_cmp_pkg::*;
(
  input  logic [HALF_FLOAT_W-1:0] float1,
  input  logic [HALF_FLOAT_W-1:0] float2,
  input  fpu_cmp_rm_t             op,
  output logic                    out
);
  logic        nan1, nan2, any_nan, both_zero, sign1, sign2;
  logic [14:0] mag1, mag2;
  logic        eq, lt;

  assign sign1     = float1[15];
  assign sign2     = float2[15];
  assign mag1      = float1[14:0];
  assign mag2      = float2[14:0];
  assign nan1      = (float1[14:10] == 5'h1f) && (float1[9:0] != 10'h0);
  assign nan2      = (float2[14:10] == 5'h1f) && (float2[9:0] != 10'h0);
  assign any_nan   = nan1 || nan2;
  assign both_zero = (mag1 == 15'h0) && (mag2 == 15'h0);

  always_comb begin
    eq = 1'b0;
    lt = 1'b0;
    if (!any_nan) begin
      eq = (float1 == float2) || both_zero;
      if (both_zero)
        lt = 1'b0;
      else if (sign1 != sign2)
        lt = sign1;
      else if (!sign1)
        lt = mag1 < mag2;
      else
        lt = mag1 > mag2;
    end
  end

  always_comb begin
    out = 1'b0;
    case (op)
      CMP_LE:  out = lt || eq;
      CMP_LT:  out = lt;
      CMP_EQ:  out = eq;
      default: out = 1'b0;
    endcase
  end
endmodule

module fpu_cmp_arbiter_16bit
  import fpu_cmp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic        [NUM_REQ-1:0]                  req_valid,
  output logic        [NUM_REQ-1:0]                  req_ready,
  input  logic        [NUM_REQ-1:0][HALF_FLOAT_W-1:0] req_float1,
  input  logic        [NUM_REQ-1:0][HALF_FLOAT_W-1:0] req_float2,
  input  fpu_cmp_rm_t [NUM_REQ-1:0]                  req_op,
  output logic                                       resp_valid,
  input  logic                                       resp_ready,
  output logic        [ID_W-1:0]                     resp_id,
  output logic                                       resp_out,
  output logic                                       busy
);
  logic [ID_W-1:0]         last_grant;
  logic [ID_W-1:0]         gnt_idx;
  logic                    gnt_vld;
  logic                    slot_free;
  logic                    do_grant;
  logic [HALF_FLOAT_W-1:0] cmp_a, cmp_b;
  fpu_cmp_rm_t             cmp_op;
  logic                    cmp_res;

  assign slot_free = !resp_valid || resp_ready;
  assign do_grant  = !RST && slot_free && gnt_vld;

  // Scan starts one past the last winner, so the previous owner has lowest priority.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!gnt_vld && req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (do_grant)
      req_ready[gnt_idx] = 1'b1;
  end

  assign cmp_a  = req_float1[gnt_idx];
  assign cmp_b  = req_float2[gnt_idx];
  assign cmp_op = req_op[gnt_idx];

  float_compare_16bit u_cmp (
    .float1 (cmp_a),
    .float2 (cmp_b),
    .op     (cmp_op),
    .out    (cmp_res)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_out   <= 1'b0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (slot_free) begin
      if (gnt_vld) begin
        resp_valid <= 1'b1;
        resp_id    <= gnt_idx;
        resp_out   <= cmp_res;
        last_grant <= gnt_idx;
      end else begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign busy = resp_valid || (|req_valid);
endmodule

// File: doc/fpu_cmp_arbiter_16bit.md
FPU_CMP_ARBITER_16BIT -- requirements
Module: fpu_cmp_arbiter_16bit

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one half-precision comparator (legal 2..8).
REQ-002 Parameter: ID_W, default $clog2(NUM_REQ), width of the requester index.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester compare request.
REQ-006 Port: req_ready  output  NUM_REQ  per-requester accept; at most one bit set per cycle.
REQ-007 Port: req_float1  input  NUM_REQ x HALF_FLOAT_W  first operand per requester.
REQ-008 Port: req_float2  input  NUM_REQ x HALF_FLOAT_W  second operand per requester.
REQ-009 Port: req_op  input  NUM_REQ x fpu_cmp_rm_t  compare operation per requester.
REQ-010 Port: resp_valid  output  1  registered result available.
REQ-011 Port: resp_ready  input  1  consumer accepts result.
REQ-012 Port: resp_id  output  ID_W  index of the requester that owns the result.
REQ-013 Port: resp_out  output  1  compare result.
REQ-014 Port: busy  output  1  high when resp_valid or any req_valid is high.

Function
REQ-015 Block SHALL instantiate exactly one float_compare_16bit, its inputs muxed from the granted requester.
REQ-016 Output slot "free" = !resp_valid || resp_ready; grants SHALL occur only while the slot is free.
REQ-017 While the slot is free and any req_valid is high, exactly one grant SHALL be issued, combinationally, as req_ready[g]=1.
REQ-018 Arbitration is round-robin: search starts at (last_grant+1) mod NUM_REQ and takes the first valid index.
REQ-019 last_grant SHALL update to g only on a grant cycle; otherwise it holds.
REQ-020 On a grant, next edge SHALL load resp_valid=1, resp_id=g, resp_out=comparator output for requester g's operands and op; latency is 1 cycle.
REQ-021 Slot free and no req_valid: resp_valid SHALL go 0 next edge if resp_ready is high, otherwise hold.
REQ-022 Slot not free (resp_valid=1, resp_ready=0): req_ready SHALL be all 0; resp_valid, resp_id, resp_out SHALL hold.
REQ-023 Simultaneous drain and grant (resp_valid=1, resp_ready=1, grant) SHALL replace the result in the same edge with no bubble; sustained throughput is 1 compare/cycle.
REQ-024 req_ready SHALL depend on neither req_float1/2 nor req_op.
REQ-025 Requesters SHALL hold valid, operands and op stable until ready; a valid deasserted before grant is dropped without side effects.
REQ-026 NaN, infinity and zero semantics SHALL be those of float_compare_16bit, passed through unmodified.
REQ-027 Pointer wrap: after grant to NUM_REQ-1, search SHALL start at index 0.

Reset
REQ-028 RST high SHALL asynchronously force resp_valid=0, resp_id=0, resp_out=0 and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-029 req_ready SHALL be all 0 while RST is high.
REQ-030 Reset mid-operation SHALL discard any held result; no response for that request is ever produced.
REQ-031 After RST falls, the first edge with a valid request SHALL behave as a normal grant.

Verification
REQ-032 Single request: req_valid=0001, float1=0x3C00 (1.0), float2=0x4000 (2.0), op=less-than, resp_ready=1 -> req_ready=0001 same cycle; next cycle resp_valid=1, resp_id=0, resp_out=1.
REQ-033 Fairness: all four valid continuously, resp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, one response per cycle, no bubbles.
REQ-034 Backpressure: resp_ready=0 for 3 cycles with a result held and req_valid=1111 -> req_ready=0000 and resp outputs stable for 3 cycles; resp_ready=1 -> next grant goes to the following index in rotation.
REQ-035 NaN passthrough: float1=0x7E00, float2=0x7E00, op=equal -> resp_out equals the standalone float_compare_16bit output for the same inputs (0).
REQ-036 Reset mid-flight: assert RST with resp_valid=1, resp_id=2 held -> resp_valid=0 immediately (asynchronous); after release with req_valid=1111 the first grant is index 0.
REQ-037 Wrap and skip: last_grant=3, req_valid=0100 -> grant index 2; then req_valid=0011 -> grant index 0.
